zueirai_alu_arbiter: RTL and testbench

Two-port round-robin arbiter and sequencer that shares the single combinational 8-bit ZueiraI ALU between two requesters, such as the instruction datapath and a debug/DMA port. It accepts one operation at a time over a valid/ready request channel and latches the operands. It drives the ALU from those registers for one execute cycle, captures the result and flags, and returns them on the winner's valid/ready response channel.

---
 rtl/zueirai_alu_arbiter.sv | 121 ++++++++++++
 tb/tb_zueirai_alu_arbiter.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/zueirai_alu_arbiter.sv
// Two-port arbiter/sequencer sharing one combinational 8-bit ZueiraI ALU.
// Flow is IDLE (grant + latch) -> EXEC (drive ALU) -> RESP (hold result until consumed).
module zueirai_alu_arbiter #(
  parameter bit PRIO_FIXED = 1'b0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       req0_valid,
  output logic       req0_ready,
  input  logic [2:0] req0_op,
  input  logic [7:0] req0_a,
  input  logic [7:0] req0_b,
  output logic       rsp0_valid,
  input  logic       rsp0_ready,
  output logic [7:0] rsp0_data,
  output logic [2:0] rsp0_flags,
  input  logic       req1_valid,
  output logic       req1_ready,
  input  logic [2:0] req1_op,
  input  logic [7:0] req1_a,
  input  logic [7:0] req1_b,
  output logic       rsp1_valid,
  input  logic       rsp1_ready,
  output logic [7:0] rsp1_data,
  output logic [2:0] rsp1_flags,
  output logic [7:0] alu_in1,
  output logic [7:0] alu_in2,
  output logic [2:0] alu_ctrl,
  input  logic [7:0] alu_out,
  input  logic [2:0] alu_flags,
  output logic       busy
);

  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

  typedef struct packed {
    logic [2:0] op;
    logic [7:0] a;
    logic [7:0] b;
  } req_t;

  state_t     r_state, w_next;
  logic       r_grant, r_last_grant;
  req_t       r_req;
  logic [7:0] r_res;
  logic [2:0] r_flags;

  logic       w_any, w_win, w_rsp_hs, w_flag_op;
  req_t       w_sel;
  logic [2:0] w_flags_cap;

  assign w_any = req0_valid | req1_valid;

  // A lone requester always wins; ties go to the port that was not granted last.
  always_comb begin
    w_win = 1'b0;
    if (req0_valid && req1_valid) w_win = PRIO_FIXED ? 1'b0 : ~r_last_grant;
    else if (req1_valid)          w_win = 1'b1;
  end

  assign w_sel = w_win ? req_t'{req1_op, req1_a, req1_b}
                       : req_t'{req0_op, req0_a, req0_b};

  // Logic ops leave the ALU flags stale, so only arithmetic/shift ops pass them.
  always_comb begin
    w_flag_op = 1'b0;
    case (r_req.op)
      3'd1, 3'd2, 3'd6, 3'd7: w_flag_op = 1'b1;
      default:                w_flag_op = 1'b0;
    endcase
  end
  assign w_flags_cap = w_flag_op ? alu_flags : 3'b000;

  assign w_rsp_hs = (r_state == RESP) && (r_grant ? rsp1_ready : rsp0_ready);

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (w_any) w_next = EXEC;
      EXEC:    w_next = RESP;
      RESP:    if (w_rsp_hs) w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state      <= IDLE;
      r_grant      <= 1'b0;
      r_last_grant <= 1'b1;
      r_req        <= '0;
      r_res        <= '0;
      r_flags      <= '0;
    end else begin
      r_state <= w_next;
      if (r_state == IDLE && w_any) begin
        r_req        <= w_sel;
        r_grant      <= w_win;
        r_last_grant <= w_win;
      end
      if (r_state == EXEC) begin
        r_res   <= alu_out;
        r_flags <= w_flags_cap;
      end
    end
  end

  assign req0_ready = (r_state == IDLE) && w_any && !w_win;
  assign req1_ready = (r_state == IDLE) && w_any &&  w_win;
  assign rsp0_valid = (r_state == RESP) && !r_grant;
  assign rsp1_valid = (r_state == RESP) &&  r_grant;
  assign rsp0_data  = r_res;
  assign rsp1_data  = r_res;
  assign rsp0_flags = r_flags;
  assign rsp1_flags = r_flags;
  assign alu_in1    = r_req.a;
  assign alu_in2    = r_req.b;
  assign alu_ctrl   = (r_state == EXEC) ? r_req.op : 3'd0;
  assign busy       = (r_state != IDLE);

endmodule

// File: tb/tb_zueirai_alu_arbiter.sv
// Directed bench: a round-robin and a fixed-priority arbiter share all request/response
// inputs, each with its own behavioural ALU that drives garbage flags on logic ops.
module tb_zueirai_alu_arbiter;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       req0_valid = 0, req1_valid = 0, rsp0_ready = 0, rsp1_ready = 0;
  logic [2:0] req0_op = 0, req1_op = 0;
  logic [7:0] req0_a = 0, req0_b = 0, req1_a = 0, req1_b = 0;

  logic       req0_ready, req1_ready, rsp0_valid, rsp1_valid, busy;
  logic [7:0] rsp0_data, rsp1_data, alu_in1, alu_in2, alu_out;
  logic [2:0] rsp0_flags, rsp1_flags, alu_ctrl, alu_flags;

  logic       f_req0_ready, f_req1_ready, f_rsp0_valid, f_rsp1_valid, f_busy;
  logic [7:0] f_rsp0_data, f_rsp1_data, f_alu_in1, f_alu_in2, f_alu_out;
  logic [2:0] f_rsp0_flags, f_rsp1_flags, f_alu_ctrl, f_alu_flags;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  // Flags {O,U,Z}; logic ops and nop return 3'b111 to model stale flags.
  function automatic logic [10:0] alu_m(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b);
    logic [8:0] s;
    logic [7:0] r;
    logic [2:0] f;
    r = 8'd0;
    f = 3'b111;
    s = 9'd0;
    case (op)
      3'd1: begin s = {1'b0, a} + {1'b0, b}; r = s[7:0]; f = {s[8], 1'b0, (r == 8'd0)}; end
      3'd2: if (a < b) begin r = 8'd0; f = 3'b010; end
            else begin r = a - b; f = {2'b00, (r == 8'd0)}; end
      3'd3: r = a & b;
      3'd4: r = a | b;
      3'd5: r = ~a;
      3'd6: begin r = {a[6:0], 1'b0}; f = {a[7], 1'b0, (r == 8'd0)}; end
      3'd7: begin r = {1'b0, a[7:1]}; f = {1'b0, a[0], (r == 8'd0)}; end
      default: r = 8'd0;
    endcase
    return {f, r};
  endfunction

  assign {alu_flags, alu_out}     = alu_m(alu_ctrl, alu_in1, alu_in2);
  assign {f_alu_flags, f_alu_out} = alu_m(f_alu_ctrl, f_alu_in1, f_alu_in2);

  zueirai_alu_arbiter #(.PRIO_FIXED(1'b0)) dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_op(req0_op), .req0_a(req0_a), .req0_b(req0_b),
    .rsp0_valid(rsp0_valid), .rsp0_ready(rsp0_ready), .rsp0_data(rsp0_data), .rsp0_flags(rsp0_flags),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_op(req1_op), .req1_a(req1_a), .req1_b(req1_b),
    .rsp1_valid(rsp1_valid), .rsp1_ready(rsp1_ready), .rsp1_data(rsp1_data), .rsp1_flags(rsp1_flags),
    .alu_in1(alu_in1), .alu_in2(alu_in2), .alu_ctrl(alu_ctrl), .alu_out(alu_out), .alu_flags(alu_flags),
    .busy(busy)
  );

  zueirai_alu_arbiter #(.PRIO_FIXED(1'b1)) dut_f (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_ready(f_req0_ready), .req0_op(req0_op), .req0_a(req0_a), .req0_b(req0_b),
    .rsp0_valid(f_rsp0_valid), .rsp0_ready(rsp0_ready), .rsp0_data(f_rsp0_data), .rsp0_flags(f_rsp0_flags),
    .req1_valid(req1_valid), .req1_ready(f_req1_ready), .req1_op(req1_op), .req1_a(req1_a), .req1_b(req1_b),
    .rsp1_valid(f_rsp1_valid), .rsp1_ready(rsp1_ready), .rsp1_data(f_rsp1_data), .rsp1_flags(f_rsp1_flags),
    .alu_in1(f_alu_in1), .alu_in2(f_alu_in2), .alu_ctrl(f_alu_ctrl), .alu_out(f_alu_out), .alu_flags(f_alu_flags),
    .busy(f_busy)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // One isolated transaction on a single port, checked at T, T+1, T+2 and T+3.
  task automatic run_op(input bit port, input logic [2:0] op, input logic [7:0] a, input logic [7:0] b,
                        input logic [7:0] exp_d, input logic [2:0] exp_f);
    tick;
    rsp0_ready = 1'b1;
    rsp1_ready = 1'b1;
    if (port) begin req1_valid = 1'b1; req1_op = op; req1_a = a; req1_b = b; end
    else      begin req0_valid = 1'b1; req0_op = op; req0_a = a; req0_b = b; end
    #1;
    chk("grant_ready", {req1_ready, req0_ready}, port ? 2'b10 : 2'b01);
    chk("idle_busy", busy, 1'b0);
    tick;
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    #1;
    chk("exec_ctrl", alu_ctrl, op);
    chk("exec_in", {alu_in1, alu_in2}, {a, b});
    chk("exec_no_rsp", {rsp1_valid, rsp0_valid, busy}, 3'b001);
    tick;
    chk("rsp_valid", {rsp1_valid, rsp0_valid}, port ? 2'b10 : 2'b01);
    chk("rsp_data", port ? rsp1_data : rsp0_data, exp_d);
    chk("rsp_flags", port ? rsp1_flags : rsp0_flags, exp_f);
    chk("rsp_ctrl0", alu_ctrl, 3'd0);
    tick;
    chk("back_idle", {busy, rsp1_valid, rsp0_valid}, 3'b000);
    chk("alu_in_hold", alu_in1, a);
  endtask

  initial begin
    int n, nf;
    #3;
    chk("rst_ready", {req1_ready, req0_ready, rsp1_valid, rsp0_valid, busy}, 5'd0);
    chk("rst_data", {rsp0_data, rsp1_data, rsp0_flags, rsp1_flags}, 22'd0);
    chk("rst_alu", {alu_in1, alu_in2, alu_ctrl}, 19'd0);
    tick;
    tick;
    rst = 1'b1;

    run_op(1'b0, 3'd1, 8'd3,    8'd4,    8'd7,    3'b000);
    run_op(1'b0, 3'd6, 8'h81,   8'h00,   8'h02,   3'b100);
    run_op(1'b0, 3'd3, 8'hF0,   8'h3C,   8'h30,   3'b000);
    run_op(1'b1, 3'd1, 8'd200,  8'd100,  8'h2C,   3'b100);
    run_op(1'b1, 3'd2, 8'd5,    8'd7,    8'h00,   3'b010);

    // Back-pressure on port 0 while port 1 waits; last grant was port 1 so port 0 wins.
    tick;
    rsp0_ready = 1'b0;
    rsp1_ready = 1'b1;
    req0_valid = 1'b1; req0_op = 3'd4; req0_a = 8'h0F; req0_b = 8'hF0;
    req1_valid = 1'b1; req1_op = 3'd1; req1_a = 8'd1;  req1_b = 8'd1;
    #1;
    chk("bp_grant", {req1_ready, req0_ready}, 2'b01);
    tick;
    req0_valid = 1'b0;
    #1;
    chk("bp_exec_r1", req1_ready, 1'b0);
    for (int i = 0; i < 10; i++) begin
      tick;
      chk("bp_hold", {rsp0_valid, rsp0_data, rsp0_flags, req1_ready, rsp1_valid}, {1'b1, 8'hFF, 3'b000, 2'b00});
    end
    rsp0_ready = 1'b1;
    #1;
    chk("bp_hs_valid", {rsp0_valid, req1_ready}, 2'b10);
    tick;
    chk("bp_r1_grant", {req1_ready, req0_ready}, 2'b10);
    tick;
    req1_valid = 1'b0;
    tick;
    chk("bp_r1_rsp", {rsp1_valid, rsp1_data, rsp1_flags}, {1'b1, 8'd2, 3'b000});
    tick;

    // Asynchronous reset in the middle of EXEC.
    req0_valid = 1'b1; req0_op = 3'd1; req0_a = 8'd9; req0_b = 8'd9;
    tick;
    req0_valid = 1'b0;
    #1;
    chk("mid_exec", alu_ctrl, 3'd1);
    #1;
    rst = 1'b0;
    #1;
    chk("mid_rst_alu", {alu_in1, alu_in2, alu_ctrl, busy}, 20'd0);
    chk("mid_rst_rsp", {rsp0_valid, rsp1_valid, rsp0_data, rsp0_flags}, 13'd0);
    tick;
    tick;
    rst = 1'b1;
    tick;
    chk("post_rst_idle", {rsp0_valid, rsp1_valid, busy}, 3'd0);

    // Continuous contention: round-robin alternates from port 0, fixed priority keeps port 0.
    req0_valid = 1'b1; req0_op = 3'd4; req0_a = 8'h01; req0_b = 8'h02;
    req1_valid = 1'b1; req1_op = 3'd4; req1_a = 8'h10; req1_b = 8'h20;
    #1;
    n = 0;
    nf = 0;
    for (int c = 0; c < 40 && (n < 6 || nf < 6); c++) begin
      if (n < 6 && (req0_ready || req1_ready)) begin
        chk("rr_grant", {req1_ready, req0_ready}, (n % 2) ? 2'b10 : 2'b01);
        n++;
      end
      if (nf < 6 && (f_req0_ready || f_req1_ready)) begin
        chk("fixed_grant", {f_req1_ready, f_req0_ready}, 2'b01);
        nf++;
      end
      tick;
    end
    chk("rr_count", n, 6);
    chk("fixed_count", nf, 6);
    req0_valid = 1'b0;
    req1_valid = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
